// File: rtl/ping_pong_ctrl_if.sv
// Bus between the debounce/onepulse front end, the ping-pong run controller and the counter.
// The controller uses the slave modport. The front end/counter side uses the master modport.
interface ping_pong_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             tick;
  logic [WIDTH-1:0] sw_max;
  logic [WIDTH-1:0] sw_min;
  logic             btn_load;
  logic             btn_run;
  logic             btn_flip;
  logic [WIDTH-1:0] max;
  logic [WIDTH-1:0] min;
  logic             enable;
  logic             flip;
  logic             cnt_clear;
  logic             cfg_err;
  logic [1:0]       state;
  logic [7:0]       flip_cnt;

  modport master (
    output tick, sw_max, sw_min, btn_load, btn_run, btn_flip,
    input  max, min, enable, flip, cnt_clear, cfg_err, state, flip_cnt
  );

  modport slave (
    input  tick, sw_max, sw_min, btn_load, btn_run, btn_flip,
    output max, min, enable, flip, cnt_clear, cfg_err, state, flip_cnt
  );
endinterface

// File: rtl/ping_pong_ctrl.sv
// Run/config controller for the ping-pong counter: bound validation, run gating, tick-aligned flips.
// Optional PPC_AUTO_FLIP_EN adds a periodic flip request every AUTO_FLIP_TICKS ticks in RUN.
module ping_pong_ctrl #(
  parameter int unsigned      WIDTH           = 4,
  parameter logic [WIDTH-1:0] MAX_INIT        = 4'd9,
  parameter logic [WIDTH-1:0] MIN_INIT        = 4'd0,
  parameter int unsigned      AUTO_FLIP_TICKS = 16
) (
  input logic             clk,
  input logic             reset,
  ping_pong_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] max_q, max_n;
  logic [WIDTH-1:0] min_q, min_n;
  logic             enable_q, enable_n;
  logic             flip_q, flip_n;
  logic             clear_q, clear_n;
  logic             err_q, err_n;
  logic             pend_q, pend_n;
  logic [7:0]       cnt_q, cnt_n;

`ifdef PPC_AUTO_FLIP_EN
  localparam int unsigned AW = (AUTO_FLIP_TICKS > 1) ? $clog2(AUTO_FLIP_TICKS) : 1;
  logic [AW-1:0] auto_q, auto_n;
`endif

  always_comb begin
    state_n = state_q;
    max_n   = max_q;
    min_n   = min_q;
    err_n   = err_q;
    clear_n = 1'b0;
    pend_n  = pend_q;
    flip_n  = 1'b0;
`ifdef PPC_AUTO_FLIP_EN
    auto_n  = auto_q;
`endif

    // Flip delivery and new requests first; load/ERR below may override the pending flag.
    if (bus.tick && (state_q == RUN) && pend_q) begin
      flip_n = 1'b1;
      pend_n = 1'b0;
    end
    if (bus.btn_flip) begin
      pend_n = 1'b1;
    end

`ifdef PPC_AUTO_FLIP_EN
    if (bus.tick && (state_q == RUN)) begin
      if (auto_q == AW'(AUTO_FLIP_TICKS - 1)) begin
        auto_n = '0;
        pend_n = 1'b1;
      end else begin
        auto_n = auto_q + 1'b1;
      end
    end
`endif

    if (bus.btn_load) begin
      if (bus.sw_min < bus.sw_max) begin
        max_n   = bus.sw_max;
        min_n   = bus.sw_min;
        err_n   = 1'b0;
        clear_n = 1'b1;
        pend_n  = 1'b0;
        state_n = RUN;
`ifdef PPC_AUTO_FLIP_EN
        auto_n  = '0;
`endif
      end else begin
        err_n   = 1'b1;
        state_n = ERR;
      end
    end else if (bus.btn_run) begin
      unique case (state_q)
        IDLE:    state_n = RUN;
        RUN:     state_n = PAUSE;
        PAUSE:   state_n = RUN;
        default: state_n = state_q;
      endcase
    end

    if (state_n == ERR) begin
      pend_n = 1'b0;
    end

    enable_n = (state_n == RUN);
    cnt_n    = (flip_n && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      max_q    <= MAX_INIT;
      min_q    <= MIN_INIT;
      enable_q <= 1'b0;
      flip_q   <= 1'b0;
      clear_q  <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef PPC_AUTO_FLIP_EN
      auto_q   <= '0;
`endif
    end else begin
      state_q  <= state_n;
      max_q    <= max_n;
      min_q    <= min_n;
      enable_q <= enable_n;
      flip_q   <= flip_n;
      clear_q  <= clear_n;
      err_q    <= err_n;
      pend_q   <= pend_n;
      cnt_q    <= cnt_n;
`ifdef PPC_AUTO_FLIP_EN
      auto_q   <= auto_n;
`endif
    end
  end

  assign bus.max       = max_q;
  assign bus.min       = min_q;
  assign bus.enable    = enable_q;
  assign bus.flip      = flip_q;
  assign bus.cnt_clear = clear_q;
  assign bus.cfg_err   = err_q;
  assign bus.state     = state_q;
  assign bus.flip_cnt  = cnt_q;

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Scoreboard bench for ping_pong_ctrl: an event-level model predicts every cycle's outputs.
// The monitor compares these predictions after each clock edge.
module tb_ping_pong_ctrl;
  localparam int unsigned W      = 4;
  localparam int unsigned AUTO_T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ping_pong_ctrl_if #(.WIDTH(W)) bus ();

  ping_pong_ctrl #(
    .WIDTH(W),
    .MAX_INIT(4'd9),
    .MIN_INIT(4'd0),
    .AUTO_FLIP_TICKS(AUTO_T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] state;
    logic [3:0] max;
    logic [3:0] min;
    logic       enable;
    logic       flip;
    logic       clr;
    logic       err;
    logic [7:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: state 0=IDLE 1=RUN 2=PAUSE 3=ERR
  int m_state, m_max, m_min, m_pend, m_auto, m_cnt;
  bit m_en, m_flip, m_clr, m_err;

  task automatic cycle(input bit rst, input bit tk, input int smax, input int smin,
                       input bit ld, input bit rn, input bit fl);
    bit delivered;
    obs_t o;
    @(negedge clk);
    reset        = rst;
    bus.tick     = tk;
    bus.sw_max   = 4'(smax);
    bus.sw_min   = 4'(smin);
    bus.btn_load = ld;
    bus.btn_run  = rn;
    bus.btn_flip = fl;
    if (rst) begin
      m_state = 0; m_max = 9; m_min = 0; m_pend = 0; m_auto = 0; m_cnt = 0;
      m_en = 0; m_flip = 0; m_clr = 0; m_err = 0;
    end else begin
      delivered = tk && (m_state == 1) && (m_pend != 0);
      m_flip = delivered;
      if (delivered) m_pend = 0;
      if (fl) m_pend = 1;
`ifdef PPC_AUTO_FLIP_EN
      if (tk && m_state == 1) begin
        m_auto++;
        if (m_auto == AUTO_T) begin
          m_auto = 0;
          m_pend = 1;
        end
      end
`endif
      m_clr = 0;
      if (ld) begin
        if (smin < smax) begin
          m_max = smax; m_min = smin; m_err = 0; m_clr = 1; m_pend = 0; m_state = 1; m_auto = 0;
        end else begin
          m_err = 1; m_state = 3;
        end
      end else if (rn) begin
        if (m_state == 0 || m_state == 2) m_state = 1;
        else if (m_state == 1) m_state = 2;
      end
      if (m_state == 3) m_pend = 0;
      m_en = (m_state == 1);
      if (m_flip && m_cnt < 255) m_cnt++;
    end
    o.state = 2'(m_state); o.max = 4'(m_max); o.min = 4'(m_min);
    o.enable = m_en; o.flip = m_flip; o.clr = m_clr; o.err = m_err; o.cnt = 8'(m_cnt);
    exp_q.push_back(o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tickc(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a full output snapshot
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.state = bus.state; a.max = bus.max; a.min = bus.min; a.enable = bus.enable;
        a.flip = bus.flip; a.clr = bus.cnt_clear; a.err = bus.cfg_err; a.cnt = bus.flip_cnt;
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs t=%0t got st=%0d max=%0d min=%0d en=%0b flip=%0b clr=%0b err=%0b cnt=%0d required st=%0d max=%0d min=%0d en=%0b flip=%0b clr=%0b err=%0b cnt=%0d",
                   $time, a.state, a.max, a.min, a.enable, a.flip, a.clr, a.err, a.cnt,
                   e.state, e.max, e.min, e.enable, e.flip, e.clr, e.err, e.cnt);
        end
      end
    end
  end

  initial begin
    int smax, smin;
    bus.tick = 0; bus.sw_max = '0; bus.sw_min = '0;
    bus.btn_load = 0; bus.btn_run = 0; bus.btn_flip = 0;

    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(5);

    cycle(0, 0, 12, 3, 1, 0, 0);
    idle(2);
    cycle(0, 0, 5, 5, 1, 0, 0);
    idle(1);
    cycle(0, 0, 0, 0, 0, 1, 0);
    idle(1);
    cycle(0, 0, 7, 2, 1, 0, 0);
    idle(1);

    // triple flip request collapses to one delivery
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1);
    tickc(1); idle(2); tickc(1); idle(1);

    // flip retained over a pause
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    tickc(2);
    cycle(0, 0, 0, 0, 0, 1, 0);
    tickc(1); idle(1);

    // request on a delivering tick re-arms
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 0, 1);
    tickc(1); idle(1);

    // load beats run from PAUSE
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 14, 1, 1, 1, 0);
    idle(1);

    // reset with a pending flip
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    tickc(3);
    cycle(0, 0, 0, 0, 0, 1, 0);
    tickc(3);

    // boundary bounds: min=0,max=15 valid; 15/15 invalid; 0/1 valid
    cycle(0, 0, 15, 0, 1, 0, 0);
    cycle(0, 0, 15, 15, 1, 0, 0);
    cycle(0, 0, 1, 0, 1, 0, 0);
    idle(1);

    // flip_cnt saturation
    cycle(0, 0, 9, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 1);
      tickc(1);
    end
    idle(2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      smax = int'($urandom_range(0, 15));
      smin = ($urandom_range(0, 3) == 0) ? smax : int'($urandom_range(0, 15));
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 3) == 0),
            smax, smin,
            ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 5) == 0));
    end
    idle(2);

    @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
